// File: rtl/pipe_stage_elastic_pkg.sv
// Shared literals for the elastic pipeline stage: reset level, valid encodings
// and occupancy codes.
package pipe_stage_elastic_pkg;

  localparam logic RST_ACT = 1'b0;
  localparam logic VLD     = 1'b1;
  localparam logic INVLD   = 1'b0;

  localparam int unsigned OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
//   clk : rising-edge clock
//   rst : synchronous reset, 0 = reset
//   en  : increment request; ignored once q is all-ones
//   q   : count value
module pipe_sat_counter
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      q <= '0;
    end else if (en && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, flush-to-bubble and saturating perf counters.
//   clk, rst            : clock, synchronous active-low reset
//   rdy                 : global enable; 0 freezes everything but flush/reset
//   flush               : drop every held beat at the next edge
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occupancy           : number of beats held
//   stall_cnt/flush_cnt : saturating stall and effective-flush counters
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       SKID    = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              acc;
  logic              pop;
  logic              rst_done;
  logic              main_v_nxt;
  logic [DATA_W-1:0] main_d_nxt;
  logic [OCC_W-1:0]  occ_nxt;

  assign acc = in_valid & in_ready;
  assign pop = rdy & out_valid & out_ready;

  if (SKID == 0) begin : g_single
    // Single entry: a beat can enter as the held one leaves.
    assign in_ready = rst_done & rdy & ~flush & (~out_valid | out_ready);

    always_comb begin
      main_v_nxt = out_valid;
      main_d_nxt = out_data;
      if (flush) begin
        main_v_nxt = INVLD;
        main_d_nxt = NOP_VAL;
      end else if (acc) begin
        main_v_nxt = VLD;
        main_d_nxt = in_data;
      end else if (pop) begin
        main_v_nxt = INVLD;
        main_d_nxt = NOP_VAL;
      end
      occ_nxt = main_v_nxt ? OCC_ONE : OCC_EMPTY;
    end
  end else begin : g_skid
    logic              skid_v;
    logic              skid_v_nxt;
    logic [DATA_W-1:0] skid_d;
    logic [DATA_W-1:0] skid_d_nxt;

    // Ready comes from registered skid state only, never from out_ready.
    assign in_ready = rst_done & rdy & ~flush & ~skid_v;

    always_comb begin
      main_v_nxt = out_valid;
      main_d_nxt = out_data;
      skid_v_nxt = skid_v;
      skid_d_nxt = skid_d;
      if (flush) begin
        main_v_nxt = INVLD;
        main_d_nxt = NOP_VAL;
        skid_v_nxt = INVLD;
        skid_d_nxt = NOP_VAL;
      end else if (pop) begin
        if (skid_v) begin
          // acc cannot coincide here: in_ready is low while skid is full.
          main_v_nxt = VLD;
          main_d_nxt = skid_d;
          skid_v_nxt = INVLD;
          skid_d_nxt = NOP_VAL;
        end else if (acc) begin
          main_v_nxt = VLD;
          main_d_nxt = in_data;
        end else begin
          main_v_nxt = INVLD;
          main_d_nxt = NOP_VAL;
        end
      end else if (acc) begin
        if (!out_valid) begin
          main_v_nxt = VLD;
          main_d_nxt = in_data;
        end else begin
          skid_v_nxt = VLD;
          skid_d_nxt = in_data;
        end
      end
      occ_nxt = OCC_W'(main_v_nxt) + OCC_W'(skid_v_nxt);
    end

    always_ff @(posedge clk) begin
      if (rst == RST_ACT) begin
        skid_v <= INVLD;
        skid_d <= NOP_VAL;
      end else begin
        skid_v <= skid_v_nxt;
        skid_d <= skid_d_nxt;
      end
    end
  end

  // Main entry drives the outputs directly; rst_done holds off in_ready for
  // the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      out_valid <= INVLD;
      out_data  <= NOP_VAL;
      occupancy <= OCC_EMPTY;
      rst_done  <= 1'b0;
    end else begin
      out_valid <= main_v_nxt;
      out_data  <= main_d_nxt;
      occupancy <= occ_nxt;
      rst_done  <= 1'b1;
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (rdy & out_valid & ~out_ready),
    .q   (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush & (occupancy != OCC_EMPTY)),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: SKID=0 and SKID=1 instances side by side,
// each checked every cycle against a queue-based capacity model, plus
// directed scenario checks.
module tb_pipe_stage_elastic;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk;
  logic rst, rdy, flush, out_ready;
  logic          in_valid [2];
  logic [DW-1:0] in_data  [2];
  logic          dr       [2];
  logic          dv       [2];
  logic [DW-1:0] dd       [2];
  logic [1:0]    docc     [2];
  logic [CW-1:0] dst      [2];
  logic [CW-1:0] dfl      [2];

  int errors = 0;
  int checks = 0;

  // Model: each instance is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
  logic [DW-1:0] mq      [2][$];
  logic [DW-1:0] src     [2][$];
  logic [DW-1:0] popped  [2][$];
  logic [CW-1:0] m_stall [2];
  logic [CW-1:0] m_flush [2];
  logic          m_live  [2];
  logic          acc_last[2];
  logic          gate    [2];
  bit            m_init = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pipe_stage_elastic #(.DATA_W(DW), .SKID(0), .NOP_VAL(32'h0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(dr[0]), .in_data(in_data[0]),
    .out_valid(dv[0]), .out_ready(out_ready), .out_data(dd[0]),
    .occupancy(docc[0]), .stall_cnt(dst[0]), .flush_cnt(dfl[0])
  );

  pipe_stage_elastic #(.DATA_W(DW), .SKID(1), .NOP_VAL(32'h0), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(dr[1]), .in_data(in_data[1]),
    .out_valid(dv[1]), .out_ready(out_ready), .out_data(dd[1]),
    .occupancy(docc[1]), .stall_cnt(dst[1]), .flush_cnt(dfl[1])
  );

  function automatic logic exp_ready(int i);
    if (!m_live[i] || !rdy || flush) return 1'b0;
    if (i == 0) return (mq[0].size() == 0) || out_ready;
    return mq[1].size() < 2;
  endfunction

  // Reference model update on each rising edge.
  initial begin
    logic er, acc, pop;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          mq[i].delete();
          m_stall[i] = '0;
          m_flush[i] = '0;
          m_live[i] = 1'b0;
          acc_last[i] = 1'b0;
          m_init = 1'b1;
        end else begin
          er  = exp_ready(i);
          acc = in_valid[i] && er;
          pop = rdy && (mq[i].size() > 0) && out_ready;
          if (rdy && (mq[i].size() > 0) && !out_ready && m_stall[i] != CMAX)
            m_stall[i] = m_stall[i] + CW'(1);
          if (flush) begin
            if (mq[i].size() != 0 && m_flush[i] != CMAX) m_flush[i] = m_flush[i] + CW'(1);
            mq[i].delete();
          end else begin
            if (pop) void'(mq[i].pop_front());
            if (acc) mq[i].push_back(in_data[i]);
          end
          acc_last[i] = acc;
          m_live[i] = 1'b1;
        end
      end
    end
  end

  // Every falling edge: DUT outputs against the model.
  initial begin
    logic          ev, er;
    logic [DW-1:0] ed;
    logic [1:0]    eo;
    forever begin
      @(negedge clk);
      if (m_init) begin
        for (int i = 0; i < 2; i++) begin
          ev = mq[i].size() > 0;
          ed = ev ? mq[i][0] : '0;
          eo = 2'(mq[i].size());
          er = exp_ready(i);
          checks++;
          if (dv[i] !== ev) begin errors++; $display("FAIL mon_out_valid inst%0d t=%0t got %0b exp %0b", i, $time, dv[i], ev); end
          checks++;
          if (dd[i] !== ed) begin errors++; $display("FAIL mon_out_data inst%0d t=%0t got %h exp %h", i, $time, dd[i], ed); end
          checks++;
          if (docc[i] !== eo) begin errors++; $display("FAIL mon_occupancy inst%0d t=%0t got %0d exp %0d", i, $time, docc[i], eo); end
          checks++;
          if (dr[i] !== er) begin errors++; $display("FAIL mon_in_ready inst%0d t=%0t got %0b exp %0b", i, $time, dr[i], er); end
          checks++;
          if (dst[i] !== m_stall[i]) begin errors++; $display("FAIL mon_stall_cnt inst%0d t=%0t got %0d exp %0d", i, $time, dst[i], m_stall[i]); end
          checks++;
          if (dfl[i] !== m_flush[i]) begin errors++; $display("FAIL mon_flush_cnt inst%0d t=%0t got %0d exp %0d", i, $time, dfl[i], m_flush[i]); end
        end
      end
    end
  end

  // Drive one cycle from the per-instance sources; retire accepted beats.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = gate[i] && (src[i].size() > 0);
      in_data[i]  = (src[i].size() > 0) ? src[i][0] : '0;
    end
    #1;
    for (int i = 0; i < 2; i++)
      if (rst && rdy && dv[i] && out_ready) popped[i].push_back(dd[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (acc_last[i]) void'(src[i].pop_front());
  endtask

  task automatic clear_src();
    for (int i = 0; i < 2; i++) begin
      src[i].delete();
      popped[i].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin gate[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid inst%0d got %0b exp 0", i, dv[i]); end
      checks++; if (dd[i] !== 32'h0) begin errors++; $display("FAIL reset_out_data inst%0d got %h exp 0", i, dd[i]); end
      checks++; if (docc[i] !== 2'd0) begin errors++; $display("FAIL reset_occupancy inst%0d got %0d exp 0", i, docc[i]); end
      checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready inst%0d got %0b exp 0", i, dr[i]); end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL post_reset_in_ready inst%0d got %0b exp 0", i, dr[i]); end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dr[i] !== 1'b1) begin errors++; $display("FAIL ready_after_reset inst%0d got %0b exp 1", i, dr[i]); end
    end
  endtask

  task automatic test_stream();
    clear_src();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gate[i] = 1'b1;
      for (int k = 1; k <= 8; k++) src[i].push_back(DW'(k));
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== 1'b1 || dd[i] !== DW'(k)) begin
          errors++; $display("FAIL stream_beat inst%0d got v=%0b d=%h exp v=1 d=%h", i, dv[i], dd[i], DW'(k));
        end
      end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL stream_drained inst%0d got %0b exp 0", i, dv[i]); end
      checks++; if (dst[i] !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt inst%0d got %0d exp 0", i, dst[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp3 [3];
    exp3[0] = 32'hA; exp3[1] = 32'hB; exp3[2] = 32'hC;
    clear_src();
    for (int i = 0; i < 2; i++) begin
      gate[i] = 1'b1;
      for (int k = 0; k < 3; k++) src[i].push_back(exp3[k]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    checks++; if (docc[0] !== 2'd1) begin errors++; $display("FAIL bp_occupancy inst0 got %0d exp 1", docc[0]); end
    checks++; if (docc[1] !== 2'd2) begin errors++; $display("FAIL bp_occupancy inst1 got %0d exp 2", docc[1]); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL bp_in_ready inst%0d got %0b exp 0", i, dr[i]); end
      checks++; if (dst[i] !== 4'd5) begin errors++; $display("FAIL bp_stall_cnt inst%0d got %0d exp 5", i, dst[i]); end
      checks++; if (dd[i] !== 32'hA) begin errors++; $display("FAIL bp_head inst%0d got %h exp a", i, dd[i]); end
    end
    out_ready = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (popped[i].size() != 3) begin
        errors++; $display("FAIL bp_pop_count inst%0d got %0d exp 3", i, popped[i].size());
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (popped[i][k] !== exp3[k]) begin errors++; $display("FAIL bp_order inst%0d idx%0d got %h exp %h", i, k, popped[i][k], exp3[k]); end
        end
      end
      checks++; if (dst[i] !== 4'd5) begin errors++; $display("FAIL bp_stall_hold inst%0d got %0d exp 5", i, dst[i]); end
    end
  endtask

  task automatic test_flush();
    clear_src();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gate[i] = 1'b1;
      src[i].push_back(32'h31);
      src[i].push_back(32'h32);
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      src[i].delete();
      src[i].push_back(32'h33);
    end
    flush = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL flush_in_ready inst%0d got %0b exp 0", i, dr[i]); end
    end
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (docc[i] !== 2'd0) begin errors++; $display("FAIL flush_occupancy inst%0d got %0d exp 0", i, docc[i]); end
      checks++; if (dd[i] !== 32'h0) begin errors++; $display("FAIL flush_out_data inst%0d got %h exp 0", i, dd[i]); end
      checks++; if (dfl[i] !== 4'd1) begin errors++; $display("FAIL flush_cnt inst%0d got %0d exp 1", i, dfl[i]); end
      gate[i] = 1'b0;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL flush_dropped inst%0d got %0b exp 0", i, dv[i]); end
    end
    clear_src();
  endtask

  task automatic test_rdy();
    logic [CW-1:0] s_exp [2];
    clear_src();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin gate[i] = 1'b1; src[i].push_back(32'h41); end
    tick();
    for (int i = 0; i < 2; i++) begin
      s_exp[i] = m_stall[i];
      src[i].push_back(32'h42);
    end
    rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b1 || dd[i] !== 32'h41) begin errors++; $display("FAIL rdy_hold inst%0d got v=%0b d=%h exp v=1 d=41", i, dv[i], dd[i]); end
      checks++; if (docc[i] !== 2'd1) begin errors++; $display("FAIL rdy_occupancy inst%0d got %0d exp 1", i, docc[i]); end
      checks++; if (dst[i] !== s_exp[i]) begin errors++; $display("FAIL rdy_stall_cnt inst%0d got %0d exp %0d", i, dst[i], s_exp[i]); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (docc[i] !== 2'd0 || dv[i] !== 1'b0) begin errors++; $display("FAIL rdy_flush_empty inst%0d got occ=%0d v=%0b exp occ=0 v=0", i, docc[i], dv[i]); end
      checks++; if (dfl[i] !== 4'd2) begin errors++; $display("FAIL rdy_flush_cnt inst%0d got %0d exp 2", i, dfl[i]); end
    end
    rdy = 1'b1;
    clear_src();
  endtask

  task automatic test_reset_mid();
    clear_src();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gate[i] = 1'b1;
      src[i].push_back(32'h11);
      src[i].push_back(32'h22);
    end
    repeat (3) tick();
    checks++; if (docc[1] !== 2'd2) begin errors++; $display("FAIL mid_preload inst1 got %0d exp 2", docc[1]); end
    clear_src();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b0 || dd[i] !== 32'h0) begin errors++; $display("FAIL mid_reset_out inst%0d got v=%0b d=%h exp v=0 d=0", i, dv[i], dd[i]); end
      checks++; if (docc[i] !== 2'd0) begin errors++; $display("FAIL mid_reset_occ inst%0d got %0d exp 0", i, docc[i]); end
      checks++; if (dst[i] !== 4'd0 || dfl[i] !== 4'd0) begin errors++; $display("FAIL mid_reset_cnt inst%0d got stall=%0d flush=%0d exp 0 0", i, dst[i], dfl[i]); end
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL mid_reset_ready inst%0d got %0b exp 0", i, dr[i]); end
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_src();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin gate[i] = 1'b1; src[i].push_back(32'h51); end
    tick();
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dst[i] !== 4'd15) begin errors++; $display("FAIL sat_stall inst%0d got %0d exp 15", i, dst[i]); end
    end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dst[i] !== 4'd15) begin errors++; $display("FAIL sat_hold inst%0d got %0d exp 15", i, dst[i]); end
    end
    out_ready = 1'b1;
    repeat (3) tick();
    clear_src();
  endtask

  task automatic test_random();
    clear_src();
    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        if (src[i].size() < 3) src[i].push_back($urandom);
        gate[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; rdy = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) gate[i] = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL random_drain inst%0d got %0b exp 0", i, dv[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_rdy();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
